// File: rtl/capture_buffer.sv
// Logic-analyzer capture buffer: records i_data while the trigger's run
// qualifier is high, then streams the stored samples out oldest-first over valid/ready.
module capture_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_run,
    input  logic             i_arm,
    output logic             o_armed,
    output logic             o_capturing,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic             o_rd_last,
    input  logic             i_rd_ready
);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LAST_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            started_q, started_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_last_q, rd_last_d;
    logic            armed_q, armed_d;
    logic            capturing_q, capturing_d;
    logic            full_q, full_d;
    logic [WIDTH-1:0] rd_data_q;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             we, re;
    logic [AW-1:0]    waddr, raddr, rd_ptr_nxt;
    logic [AW:0]      last_idx;
    logic             handshake;

    assign handshake  = rd_valid_q & i_rd_ready;
    assign last_idx   = count_q - CNT_ONE;
    assign rd_ptr_nxt = rd_ptr_q + PTR_ONE;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        started_d  = started_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        we         = 1'b0;
        waddr      = wr_ptr_q;
        re         = 1'b0;
        raddr      = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (i_arm) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end
            end
            ARMED: begin
                if (i_arm) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else if (i_run) begin
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = PTR_ONE;
                    count_d  = CNT_ONE;
                    state_d  = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!i_run) begin
                    state_d = READOUT;
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                    if (count_q == LAST_CNT) state_d = READOUT;
                end
            end
            READOUT: begin
                if (i_arm) begin
                    state_d    = ARMED;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    started_d  = 1'b0;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else if (!started_q) begin
                    // First READOUT cycle only sets up address 0; the read fires next cycle.
                    started_d = 1'b1;
                end else if (!rd_valid_q) begin
                    re         = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_last_d  = ({1'b0, rd_ptr_q} == last_idx);
                end else if (handshake) begin
                    if (rd_last_q) begin
                        state_d    = IDLE;
                        started_d  = 1'b0;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        re        = 1'b1;
                        raddr     = rd_ptr_nxt;
                        rd_ptr_d  = rd_ptr_nxt;
                        rd_last_d = ({1'b0, rd_ptr_nxt} == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        armed_d     = (state_d == ARMED);
        capturing_d = (state_d == CAPTURE);
        full_d      = (count_d == FULL_CNT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            started_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            armed_q     <= 1'b0;
            capturing_q <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            started_q   <= started_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            armed_q     <= armed_d;
            capturing_q <= capturing_d;
            full_q      <= full_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) mem[waddr] <= i_data;
    end

    // Synchronous read port; the output register only loads on a read, so data holds under stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)  rd_data_q <= '0;
        else if (re)   rd_data_q <= mem[raddr];
    end

    assign o_armed     = armed_q;
    assign o_capturing = capturing_q;
    assign o_count     = count_q;
    assign o_full      = full_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_last   = rd_last_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: stimulus pushes expected beats and status
// checks into queues; a negedge monitor pops and compares them.
module tb_capture_buffer;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic [W-1:0]  i_data;
    logic          i_run;
    logic          i_arm;
    logic          o_armed;
    logic          o_capturing;
    logic [AW:0]   o_count;
    logic          o_full;
    logic [W-1:0]  o_rd_data;
    logic          o_rd_valid;
    logic          o_rd_last;
    logic          i_rd_ready;

    capture_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_run       (i_run),
        .i_arm       (i_arm),
        .o_armed     (o_armed),
        .o_capturing (o_capturing),
        .o_count     (o_count),
        .o_full      (o_full),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_rd_last   (o_rd_last),
        .i_rd_ready  (i_rd_ready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [W-1:0] d; logic last; } beat_t;
    typedef struct { string name; int act; int exp; } chk_t;

    beat_t exp_q[$];
    chk_t  chk_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic         prev_v, prev_r, prev_a;
    logic [W-1:0] prev_d;

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: drains status checks, checks every handshake against the
    // scoreboard and checks that a stalled beat holds.
    always @(negedge i_clk) begin : monitor
        chk_t  c;
        beat_t b;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (i_rst_n && prev_v && !prev_r && !prev_a) begin
            cmp("stall_valid", int'(o_rd_valid), 1);
            cmp("stall_data", int'(o_rd_data), int'(prev_d));
        end
        if (i_rst_n && o_rd_valid && i_rd_ready) begin
            if (exp_q.size() == 0) begin
                cmp("unexpected_beat", int'(o_rd_data), -1);
            end else begin
                b = exp_q.pop_front();
                cmp("rd_data", int'(o_rd_data), int'(b.d));
                cmp("rd_last", int'(o_rd_last), int'(b.last));
            end
        end
        prev_v <= i_rst_n & o_rd_valid;
        prev_r <= i_rd_ready;
        prev_a <= i_arm;
        prev_d <= o_rd_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        chk_q.push_back('{name, act, exp});
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic arm_pulse();
        i_arm = 1'b1;
        cyc();
        i_arm = 1'b0;
    endtask

    task automatic capture_seq(input int n, input logic [W-1:0] base);
        logic [W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = base + W'(i);
            exp_q.push_back('{v, (i == n - 1)});
            i_run  = 1'b1;
            i_data = v;
            cyc();
        end
        i_run = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!o_rd_valid && k < 20) begin
            cyc();
            k++;
        end
        chk("valid_seen", int'(o_rd_valid), 1);
    endtask

    task automatic wait_idle();
        int done = 0;
        for (int k = 0; k < 100 && done == 0; k++) begin
            cyc();
            if (!o_rd_valid && exp_q.size() == 0 && !o_capturing && !o_armed) done = 1;
        end
        chk("readout_done", done, 1);
    endtask

    initial begin : stim
        logic [0:6] pat;
        int k;
        i_rst_n    = 1'b0;
        i_data     = '0;
        i_run      = 1'b0;
        i_arm      = 1'b0;
        i_rd_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", int'(o_rd_valid), 0);
        chk("rst_last",  int'(o_rd_last), 0);
        chk("rst_data",  int'(o_rd_data), 0);
        chk("rst_armed", int'(o_armed), 0);
        chk("rst_cap",   int'(o_capturing), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_full",  int'(o_full), 0);
        i_rst_n = 1'b1;
        cyc();

        // Reset asserted mid-capture with five samples stored
        arm_pulse();
        chk("armed_after_arm", int'(o_armed), 1);
        for (int i = 0; i < 5; i++) begin
            i_run  = 1'b1;
            i_data = W'(8'h30 + i);
            cyc();
        end
        chk("midcap_count", int'(o_count), 5);
        chk("midcap_cap", int'(o_capturing), 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_count", int'(o_count), 0);
        chk("async_cap",   int'(o_capturing), 0);
        chk("async_armed", int'(o_armed), 0);
        chk("async_valid", int'(o_rd_valid), 0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (3) cyc();
        chk("idle_run_cap",   int'(o_capturing), 0);
        chk("idle_run_count", int'(o_count), 0);
        chk("idle_run_armed", int'(o_armed), 0);
        i_run = 1'b0;
        cyc();

        // Short capture with streaming readout and first-valid latency
        i_rd_ready = 1'b1;
        arm_pulse();
        capture_seq(4, 8'hA1);
        chk("short_count", int'(o_count), 4);
        cyc();
        chk("lat_e0", int'(o_rd_valid), 0);
        cyc();
        chk("lat_e1", int'(o_rd_valid), 0);
        cyc();
        chk("lat_e2", int'(o_rd_valid), 1);
        wait_idle();
        chk("short_count_kept", int'(o_count), 4);

        // Full buffer: run held 40 cycles, only the first 16 samples stored
        arm_pulse();
        for (int i = 0; i < D; i++) exp_q.push_back('{W'(i), (i == D - 1)});
        for (int i = 0; i < 40; i++) begin
            i_run  = 1'b1;
            i_data = W'(i);
            cyc();
            if (i == D - 1) begin
                chk("full_at16", int'(o_full), 1);
                chk("count_at16", int'(o_count), D);
                chk("cap_at16", int'(o_capturing), 0);
            end
        end
        i_run = 1'b0;
        wait_idle();
        chk("full_kept", int'(o_full), 1);
        chk("full_count_kept", int'(o_count), D);

        // Backpressure on a 4-sample readout
        i_rd_ready = 1'b0;
        arm_pulse();
        chk("arm_clears_full", int'(o_full), 0);
        capture_seq(4, 8'hB1);
        wait_valid();
        pat = 7'b1001101;
        for (int i = 0; i < 7; i++) begin
            i_rd_ready = pat[i];
            cyc();
        end
        i_rd_ready = 1'b1;
        wait_idle();

        // Abort after two of eight samples, then a fresh 3-sample capture
        i_rd_ready = 1'b0;
        arm_pulse();
        capture_seq(8, 8'hC0);
        wait_valid();
        i_rd_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 6 && k < 20) begin
            cyc();
            k++;
        end
        chk("abort_two_read", exp_q.size(), 6);
        i_rd_ready = 1'b0;
        i_arm      = 1'b1;
        cyc();
        i_arm = 1'b0;
        chk("abort_valid", int'(o_rd_valid), 0);
        chk("abort_armed", int'(o_armed), 1);
        chk("abort_count", int'(o_count), 0);
        exp_q.delete();
        capture_seq(3, 8'hD0);
        i_rd_ready = 1'b1;
        wait_idle();

        // Single-sample capture
        arm_pulse();
        capture_seq(1, 8'h5A);
        chk("single_count", int'(o_count), 1);
        wait_idle();

        chk("sb_drained", exp_q.size(), 0);
        cyc();
        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
